// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM stage: funct3 access-size codes, LSU FSM
// encoding and the default ack timeout.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // Codes outside the five defined ones fall back to a full-word access.
    function automatic mem_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM stage; the LSU is the master, the memory the slave.
// Handshake: dmem_req rises with addr/be/wdata/we valid and all of them stay
// stable until the cycle dmem_ack is high; dmem_ack is a one-cycle pulse that is
// only meaningful while dmem_req is high, and dmem_rdata is valid with it.
interface mem_stage_lsu_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store-data
// replication and load extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    mem_size_e   sz;
    logic        uns;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        sz        = size_of(funct3);
        uns       = is_unsigned(funct3);
        byte_lane = 8'(load_word >> {addr_lo, 3'b000});
        half_lane = 16'(load_word >> {addr_lo[1], 4'b0000});
        aligned   = 1'b1;
        be        = 4'hF;
        wdata     = store_data;
        load_data = load_word;
        case (sz)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = uns ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                aligned   = ~addr_lo[0];
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = uns ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                aligned = (addr_lo == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-memory access over req/ack with timeout,
// load alignment, branch resolution and the registered MEM/WB bundle.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEMMemtoReg_in,
    input  logic            MEMRegWrite_in,
    input  logic            MEMMemRead_in,
    input  logic            MEMMemWrite_in,
    input  logic            MEMBranch_in,
    input  logic            MEMZero_in,
    input  logic [31:0]     MEMADD_in,
    input  logic [31:0]     MEMALURes_in,
    input  logic [31:0]     MEMRd2_in,
    input  logic [2:0]      MEMFunct3_in,
    input  logic [4:0]      MEMRd_in,
    mem_stage_lsu_if.master mem_bus,
    output logic            stall,
    output logic            PCSrc,
    output logic [31:0]     BrTarget,
    output logic            WBMemtoReg,
    output logic            WBRegWrite,
    output logic [31:0]     WBReadData,
    output logic [31:0]     WBALURes,
    output logic [4:0]      WBRd,
    output logic            misalign,
    output logic            bus_err,
    output lsu_state_e      state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             is_memop;
    logic             aligned;
    logic             in_req;
    logic             issue;
    logic             timed_out;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      load_data;

    lsu_align u_align (
        .funct3     (MEMFunct3_in),
        .addr_lo    (MEMALURes_in[1:0]),
        .store_data (MEMRd2_in),
        .load_word  (mem_bus.dmem_rdata),
        .aligned    (aligned),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    assign is_memop  = (MEMMemRead_in | MEMMemWrite_in) & ~MEMBranch_in;
    assign in_req    = (state == ST_REQ);
    assign issue     = ~in_req & is_memop & aligned;
    assign timed_out = in_req & ~mem_bus.dmem_ack & (cnt == CNT_LAST);

    // Gating with rst drops the request and stall the moment reset asserts,
    // even while the frozen EX/MEM entry still describes a memory op.
    assign mem_bus.dmem_req   = rst & (issue | in_req);
    assign mem_bus.dmem_we    = MEMMemWrite_in;
    assign mem_bus.dmem_addr  = {MEMALURes_in[31:2], 2'b00};
    assign mem_bus.dmem_be    = be;
    assign mem_bus.dmem_wdata = wdata;

    assign stall     = rst & (issue | (in_req & ~mem_bus.dmem_ack & ~timed_out));
    assign PCSrc     = MEMBranch_in & MEMZero_in;
    assign BrTarget  = MEMADD_in;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            WBMemtoReg <= 1'b0;
            WBRegWrite <= 1'b0;
            WBReadData <= '0;
            WBALURes   <= '0;
            WBRd       <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt        <= '0;
                    WBMemtoReg <= MEMMemtoReg_in;
                    WBReadData <= '0;
                    WBALURes   <= MEMALURes_in;
                    WBRd       <= MEMRd_in;
                    if (issue) begin
                        state      <= ST_REQ;
                        WBMemtoReg <= 1'b0;
                        WBRegWrite <= 1'b0;
                    end else if (is_memop) begin
                        misalign   <= 1'b1;
                        WBRegWrite <= 1'b0;
                    end else begin
                        WBRegWrite <= MEMRegWrite_in;
                    end
                end
                ST_REQ: begin
                    if (mem_bus.dmem_ack) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        WBMemtoReg <= MEMMemtoReg_in;
                        WBRegWrite <= MEMRegWrite_in & ~MEMMemWrite_in;
                        WBReadData <= MEMMemRead_in ? load_data : 32'd0;
                        WBALURes   <= MEMALURes_in;
                        WBRd       <= MEMRd_in;
                    end else if (timed_out) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        bus_err    <= 1'b1;
                        WBMemtoReg <= 1'b0;
                        WBRegWrite <= 1'b0;
                        WBReadData <= '0;
                        WBALURes   <= MEMALURes_in;
                        WBRd       <= MEMRd_in;
                    end else begin
                        // Bubble into WB while the access is outstanding.
                        cnt        <= cnt + 1'b1;
                        WBMemtoReg <= 1'b0;
                        WBRegWrite <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed loads/stores, misalignment,
// timeout, reset during an access and a short random run against a WB scoreboard.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_to_reg, reg_write, mem_read, mem_write, branch, zero;
    logic [31:0] add_in, alu_res, rd2;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        stall, pc_src, wb_m2r, wb_rw, misalign, bus_err;
    logic [31:0] br_target, wb_rdata, wb_alu;
    logic [4:0]  wb_rd;
    lsu_state_e  state_dbg;

    mem_stage_lsu_if mem_bus ();

    mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .MEMMemtoReg_in(mem_to_reg), .MEMRegWrite_in(reg_write),
        .MEMMemRead_in(mem_read), .MEMMemWrite_in(mem_write),
        .MEMBranch_in(branch), .MEMZero_in(zero),
        .MEMADD_in(add_in), .MEMALURes_in(alu_res), .MEMRd2_in(rd2),
        .MEMFunct3_in(funct3), .MEMRd_in(rd),
        .mem_bus(mem_bus),
        .stall(stall), .PCSrc(pc_src), .BrTarget(br_target),
        .WBMemtoReg(wb_m2r), .WBRegWrite(wb_rw), .WBReadData(wb_rdata),
        .WBALURes(wb_alu), .WBRd(wb_rd),
        .misalign(misalign), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [70:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] pack_wb(input logic rw, input logic m2r, input logic [4:0] r,
                                            input logic [31:0] rdata, input logic [31:0] alu);
        return {rw, m2r, r, rdata, alu};
    endfunction

    task automatic check_wb(input string tag);
        if (exp_q.size() == 0) check({tag, "_queue"}, 0, 1);
        else check({tag, "_wb"}, {wb_rw, wb_m2r, wb_rd, wb_rdata, wb_alu}, exp_q.pop_front());
    endtask

    // Reference lane model.
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd0:    case (a) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                              2'd2: return 4'b0100; default: return 4'b1000; endcase
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (int'(a) * 8);
        case (f3[1:0])
            2'd0:    return f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    begin
                         sh = w >> (a[1] ? 16 : 0);
                         return f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                     end
            default: return w;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic set_entry(input logic rd_en, input logic wr_en, input logic rw, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdst);
        mem_read = rd_en; mem_write = wr_en; reg_write = rw; mem_to_reg = rd_en;
        branch = 1'b0; zero = 1'b0; add_in = 32'd0;
        funct3 = f3; alu_res = addr; rd2 = sdata; rd = rdst;
    endtask

    task automatic clear_entry();
        set_entry(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Entered just after a rising edge with the entry applied; returns just
    // after the edge that ends the stall (completion or timeout).
    task automatic mem_access(input string tag, input int ack_wait, input logic [31:0] rdata_v,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int k = 0; k < TIMEOUT + 8 && !done; k++) begin
            @(negedge clk);
            if (ack_wait >= 0 && k == ack_wait + 1) begin
                mem_bus.dmem_ack   = 1'b1;
                mem_bus.dmem_rdata = rdata_v;
            end
            #1;
            if (k == 0) begin
                check({tag, "_req"}, mem_bus.dmem_req, 1);
                check({tag, "_we"}, mem_bus.dmem_we, mem_write);
                check({tag, "_be"}, mem_bus.dmem_be, exp_be);
                check({tag, "_wdata"}, mem_bus.dmem_wdata, exp_wdata);
                check({tag, "_addr"}, mem_bus.dmem_addr, {alu_res[31:2], 2'b00});
            end
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            mem_bus.dmem_ack = 1'b0;
        end
        if (!done) check({tag, "_stall_bound"}, 0, 1);
    endtask

    task automatic do_access(input string tag, input logic rd_en, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdst,
                             input int ack_wait, input logic [31:0] rdata_v,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int stalls;
        exp_q.push_back(pack_wb(rd_en, rd_en, rdst, rd_en ? exp_rdata : 32'd0, addr));
        set_entry(rd_en, ~rd_en, 1'b1, f3, addr, sdata, rdst);
        mem_access(tag, ack_wait, rdata_v, exp_be, exp_wdata, stalls);
        check({tag, "_stalls"}, stalls, ack_wait + 1);
        check_wb(tag);
        clear_entry();
    endtask

    // ---------------- sequence ----------------
    initial begin
        int stalls;
        rst = 1'b0;
        mem_bus.dmem_ack = 1'b0;
        mem_bus.dmem_rdata = 32'd0;
        set_entry(1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'd0, 5'd3);

        // Reset: a pending memory entry must not raise a request.
        @(negedge clk);
        check("rst_req", mem_bus.dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wb", {wb_rw, wb_m2r, wb_rd, wb_rdata, wb_alu}, 0);
        check("rst_pulses", {misalign, bus_err}, 0);
        check("rst_state", state_dbg, ST_IDLE);
        clear_entry();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory entries pass straight through.
        set_entry(1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5);
        exp_q.push_back(pack_wb(1'b1, 1'b0, 5'd5, 32'd0, 32'h0000_1234));
        @(negedge clk);
        check("alu_stall", stall, 0);
        check("alu_req", mem_bus.dmem_req, 0);
        @(posedge clk);
        #1;
        check_wb("alu1");
        set_entry(1'b0, 1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'd0, 5'd31);
        exp_q.push_back(pack_wb(1'b0, 1'b0, 5'd31, 32'd0, 32'hCAFE_0001));
        @(posedge clk);
        #1;
        check_wb("alu2");

        // Branch resolution.
        clear_entry();
        branch = 1'b1; zero = 1'b1; add_in = 32'h0000_0040;
        #1;
        check("br_taken", {pc_src, br_target}, {1'b1, 32'h0000_0040});
        zero = 1'b0;
        #1;
        check("br_not_taken", pc_src, 0);
        clear_entry();
        @(posedge clk);
        #1;

        do_access("lw",  1'b1, F3_W,  32'h100, 32'h0, 5'd7, 0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
        do_access("lb",  1'b1, F3_B,  32'h103, 32'h0, 5'd8, 0, 32'h8000_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("lbu", 1'b1, F3_BU, 32'h103, 32'h0, 5'd9, 1, 32'h8000_0000, 4'b1000, 32'h0, 32'h0000_0080);
        do_access("sh",  1'b0, F3_H,  32'h102, 32'h0000_ABCD, 5'd10, 2, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_access("lh",  1'b1, F3_H,  32'h102, 32'h0, 5'd11, 0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_access("lhu", 1'b1, F3_HU, 32'h102, 32'h0, 5'd12, 3, 32'h8001_0000, 4'b1100, 32'h0, 32'h0000_8001);

        // Misaligned word load: no access, one-cycle misalign pulse.
        set_entry(1'b1, 1'b0, 1'b1, F3_W, 32'h101, 32'h0, 5'd13);
        @(negedge clk);
        check("mis_req", mem_bus.dmem_req, 0);
        check("mis_stall", stall, 0);
        @(posedge clk);
        #1;
        check("mis_pulse", misalign, 1);
        check("mis_regwrite", wb_rw, 0);
        clear_entry();
        @(posedge clk);
        #1;
        check("mis_pulse_end", misalign, 0);

        // Ack withheld: stall for exactly TIMEOUT cycles, then bus_err.
        set_entry(1'b1, 1'b0, 1'b1, F3_W, 32'h200, 32'h0, 5'd14);
        mem_access("tmo", -1, 32'h0, 4'hF, 32'h0, stalls);
        check("tmo_stalls", stalls, TIMEOUT);
        check("tmo_bus_err", bus_err, 1);
        check("tmo_regwrite", wb_rw, 0);
        check("tmo_state", state_dbg, ST_IDLE);
        clear_entry();
        @(posedge clk);
        #1;
        check("tmo_pulse_end", bus_err, 0);

        // Stray ack while idle is ignored.
        @(negedge clk);
        mem_bus.dmem_ack = 1'b1;
        #1;
        check("idle_ack_stall", {stall, mem_bus.dmem_req}, 0);
        @(posedge clk);
        #1;
        mem_bus.dmem_ack = 1'b0;
        check("idle_ack_state", state_dbg, ST_IDLE);

        // Reset during an outstanding request.
        set_entry(1'b1, 1'b0, 1'b1, F3_W, 32'h300, 32'h0, 5'd15);
        @(posedge clk);
        #1;
        check("rreq_state", state_dbg, ST_REQ);
        rst = 1'b0;
        #1;
        check("rreq_req", mem_bus.dmem_req, 0);
        check("rreq_stall", stall, 0);
        check("rreq_wb", {wb_rw, wb_m2r, wb_rd, wb_rdata, wb_alu}, 0);
        check("rreq_state_idle", state_dbg, ST_IDLE);
        clear_entry();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_req", mem_bus.dmem_req, 0);
            check("post_rst_state", state_dbg, ST_IDLE);
        end
        @(posedge clk);
        #1;

        // Random aligned accesses.
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, d, r;
            logic        is_load;
            int          w;
            case ($urandom_range(0, 4))
                0: f3 = F3_B;
                1: f3 = F3_H;
                2: f3 = F3_W;
                3: f3 = F3_BU;
                default: f3 = F3_HU;
            endcase
            is_load = 1'($urandom_range(0, 1));
            if (!is_load) f3[2] = 1'b0;
            a = $urandom();
            if (f3[1:0] == 2'd1) a[0] = 1'b0;
            if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            d = $urandom();
            r = $urandom();
            w = $urandom_range(0, 3);
            do_access($sformatf("rnd%0d", i), is_load, f3, a, d, 5'($urandom_range(1, 31)), w, r,
                      m_be(f3, a[1:0]), m_wdata(f3, d), m_load(f3, a[1:0], r));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
